// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin arbiter time-sharing one carry-select adder
// Result slot holds one response; a draining slot can be refilled on the same edge.

module Adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cIn,
  output logic [31:0] sum,
  output logic        cOut
);
  logic [16:0] lo;
  logic [16:0] hi0;
  logic [16:0] hi1;

  // Upper half is precomputed for both carry-ins and selected by the lower carry.
  always_comb begin
    lo        = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cIn};
    hi0       = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    hi1       = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
    sum[15:0] = lo[15:0];
    {cOut, sum[31:16]} = lo[16] ? hi1 : hi0;
  end
endmodule

module adder_share_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  i_clk_1,
  input  logic                  i_rst_1,
  input  logic [N_REQ-1:0]      i_reqValid_N,
  output logic [N_REQ-1:0]      o_reqReady_N,
  input  logic [N_REQ*32-1:0]   i_reqOp1_N32,
  input  logic [N_REQ*32-1:0]   i_reqOp2_N32,
  input  logic [N_REQ-1:0]      i_reqSub_N,
  output logic [N_REQ-1:0]      o_rspValid_N,
  input  logic [N_REQ-1:0]      i_rspReady_N,
  output logic [31:0]           o_rspSum_32,
  output logic                  o_rspCOut_1,
  output logic                  o_rspOvf_1,
  output logic [ID_W-1:0]       o_rspOwner_ID
);
  localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

  typedef enum logic {EMPTY, FULL} slotState_t;
  slotState_t state, stateNext;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    grantIdx;
  logic [ID_W-1:0]    offset;
  logic [ID_W-1:0]    ptrNext;
  logic [ID_W:0]      idxSum;
  logic [ID_W:0]      ptrSum;
  logic [2*N_REQ-1:0] dblValid;
  logic [N_REQ-1:0]   rotValid;
  logic               found;
  logic               canAccept;
  logic               accept;
  logic [31:0]        op1;
  logic [31:0]        op2Raw;
  logic [31:0]        op2Eff;
  logic               subSel;
  logic [31:0]        addSum;
  logic               addCOut;
  logic               addOvf;
  logic [31:0]        rspSum;
  logic               rspCOut;
  logic               rspOvf;

  // Rotate the valid vector so the priority pointer lands on bit 0.
  always_comb begin
    dblValid = {i_reqValid_N, i_reqValid_N} >> ptr;
    rotValid = dblValid[N_REQ-1:0];
    found    = 1'b0;
    offset   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotValid[i]) begin
        found  = 1'b1;
        offset = ID_W'(i);
      end
    end
    idxSum = {1'b0, ptr} + {1'b0, offset};
    if (idxSum >= N_REQ_W) begin
      idxSum = idxSum - N_REQ_W;
    end
    grantIdx = idxSum[ID_W-1:0];
    ptrSum   = {1'b0, grantIdx} + {{ID_W{1'b0}}, 1'b1};
    if (ptrSum >= N_REQ_W) begin
      ptrSum = '0;
    end
    ptrNext = ptrSum[ID_W-1:0];
  end

  assign canAccept    = (state == EMPTY) || ((state == FULL) && i_rspReady_N[owner]);
  assign accept       = found && canAccept;
  assign o_reqReady_N = accept ? (N_REQ'(1) << grantIdx) : '0;

  always_comb begin
    op1    = '0;
    op2Raw = '0;
    subSel = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grantIdx == ID_W'(k)) begin
        op1    = i_reqOp1_N32[32*k +: 32];
        op2Raw = i_reqOp2_N32[32*k +: 32];
        subSel = i_reqSub_N[k];
      end
    end
    op2Eff = subSel ? ~op2Raw : op2Raw;
  end

  Adder uAdder (
    .a    (op1),
    .b    (op2Eff),
    .cIn  (subSel),
    .sum  (addSum),
    .cOut (addCOut)
  );

  assign addOvf = (op1[31] == op2Eff[31]) && (addSum[31] != op1[31]);

  always_comb begin
    stateNext = state;
    case (state)
      EMPTY:   if (accept) stateNext = FULL;
      FULL:    if (i_rspReady_N[owner] && !accept) stateNext = EMPTY;
      default: stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk_1) begin
    if (i_rst_1) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge i_clk_1) begin
    if (i_rst_1) begin
      ptr     <= '0;
      owner   <= '0;
      rspSum  <= '0;
      rspCOut <= 1'b0;
      rspOvf  <= 1'b0;
    end else if (accept) begin
      ptr     <= ptrNext;
      owner   <= grantIdx;
      rspSum  <= addSum;
      rspCOut <= addCOut;
      rspOvf  <= addOvf;
    end
  end

  assign o_rspValid_N  = (state == FULL) ? (N_REQ'(1) << owner) : '0;
  assign o_rspSum_32   = rspSum;
  assign o_rspCOut_1   = rspCOut;
  assign o_rspOvf_1    = rspOvf;
  assign o_rspOwner_ID = owner;
endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - scoreboard bench for the shared-adder arbiter
// Per-requester request queues feed a protocol driver; a predictor and response monitor check the DUT.

module tb_adder_share_arb;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
  } req_t;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
    int          owner;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    reqValid = '0;
  logic [N-1:0]    reqReady;
  logic [N-1:0]    reqSub = '0;
  logic [N*32-1:0] reqOp1 = '0;
  logic [N*32-1:0] reqOp2 = '0;
  logic [N-1:0]    rspValid;
  logic [N-1:0]    rspReady = '0;
  logic [31:0]     rspSum;
  logic            rspCOut;
  logic            rspOvf;
  logic [IW-1:0]   rspOwner;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   mPtr   = 0;
  bit   randMode = 1'b0;
  logic [N-1:0] hsLast = '0;
  req_t reqQ[N][$];
  rsp_t expQ[$];
  int   grantLog[$];
  int   grantCyc[$];

  adder_share_arb #(.N_REQ(N), .ID_W(IW)) dut (
    .i_clk_1       (clk),
    .i_rst_1       (rst),
    .i_reqValid_N  (reqValid),
    .o_reqReady_N  (reqReady),
    .i_reqOp1_N32  (reqOp1),
    .i_reqOp2_N32  (reqOp2),
    .i_reqSub_N    (reqSub),
    .o_rspValid_N  (rspValid),
    .i_rspReady_N  (rspReady),
    .o_rspSum_32   (rspSum),
    .o_rspCOut_1   (rspCOut),
    .o_rspOvf_1    (rspOvf),
    .o_rspOwner_ID (rspOwner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: exact integer arithmetic, carry = unsigned overflow / no borrow.
  function automatic rsp_t model(input req_t r, input int owner);
    rsp_t   x;
    longint exact;
    x.sum = r.sub ? r.a - r.b : r.a + r.b;
    x.c   = r.sub ? (r.a >= r.b) : ((longint'(r.a) + longint'(r.b)) > 64'hFFFF_FFFF);
    exact = r.sub ? longint'($signed(r.a)) - longint'($signed(r.b))
                  : longint'($signed(r.a)) + longint'($signed(r.b));
    x.o     = (exact != longint'($signed(x.sum)));
    x.owner = owner;
    return x;
  endfunction

  function automatic logic [31:0] randOp();
    case ($urandom_range(7, 0))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic pushReq(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_t r;
    r.a = a; r.b = b; r.sub = s;
    reqQ[k].push_back(r);
  endtask

  initial begin : driver
    req_t r;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (hsLast[k]) reqValid[k] = 1'b0;
        if (randMode && !reqValid[k] && reqQ[k].size() == 0 && $urandom_range(1, 0) == 1) begin
          r.a = randOp(); r.b = randOp(); r.sub = 1'($urandom_range(1, 0));
          reqQ[k].push_back(r);
        end
        if (!reqValid[k] && reqQ[k].size() > 0) begin
          r = reqQ[k].pop_front();
          reqValid[k]         = 1'b1;
          reqOp1[32*k +: 32]  = r.a;
          reqOp2[32*k +: 32]  = r.b;
          reqSub[k]           = r.sub;
        end
      end
      if (randMode) rspReady = N'($urandom | $urandom);
      #3 hsLast = reqValid & reqReady;
    end
  end

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (expQ.size() > 0) begin
          e = expQ[0];
          check("rspValid", 64'(rspValid), 64'(N'(1) << e.owner));
          check("rspData", 64'({rspSum, rspCOut, rspOvf, rspOwner}),
                64'({e.sum, e.c, e.o, IW'(e.owner)}));
          if (rspReady[e.owner]) expQ.delete(0);
        end else begin
          check("rspIdle", 64'(rspValid), 64'(0));
        end
      end
    end
  end

  initial begin : predictor
    int   g;
    req_t q;
    logic [N-1:0] expRdy;
    forever begin
      @(negedge clk); #3;
      if (!rst) begin
        g = -1;
        if (expQ.size() == 0) begin
          for (int i = 0; i < N; i++) begin
            if (g < 0 && reqValid[(mPtr + i) % N]) g = (mPtr + i) % N;
          end
        end
        expRdy = (g >= 0) ? (N'(1) << g) : '0;
        check("reqReady", 64'(reqReady), 64'(expRdy));
        if (g >= 0) begin
          q.a   = reqOp1[32*g +: 32];
          q.b   = reqOp2[32*g +: 32];
          q.sub = reqSub[g];
          expQ.push_back(model(q, g));
          mPtr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (reqReady == (N'(1) << i)) begin
            grantLog.push_back(i);
            grantCyc.push_back(cycle);
          end
        end
      end
    end
  end

  task automatic waitRsp(input string name, input logic [31:0] s, input logic c, input logic o, input int own);
    int n = 0;
    do begin
      @(negedge clk); #4;
      n++;
    end while (rspValid == '0 && n < 30);
    if (rspValid == '0) begin
      checks++; errors++;
      $display("FAIL %s: no response within 30 cycles, expected owner %0d", name, own);
    end else begin
      check(name, 64'({rspSum, rspCOut, rspOvf, rspOwner}), 64'({s, c, o, IW'(own)}));
    end
  endtask

  task automatic resetDut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    expQ.delete();
    mPtr = 0;
  endtask

  task automatic checkZero(input string tag);
    check({tag, " reqReady"}, 64'(reqReady), 64'(0));
    check({tag, " rspValid"}, 64'(rspValid), 64'(0));
    check({tag, " rspData"}, 64'({rspSum, rspCOut, rspOvf, rspOwner}), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int busy;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4 checkZero("reset");

    rspReady = '1;
    pushReq(1, 32'h5, 32'h3, 1'b0);
    waitRsp("add5p3", 32'h8, 1'b0, 1'b0, 1);
    @(negedge clk); #4;
    check("idleDrain", 64'(rspValid), 64'(0));

    grantLog.delete();
    pushReq(1, 32'h10, 32'h1, 1'b0);
    pushReq(2, 32'h20, 32'h2, 1'b0);
    waitRsp("ptrKeep2", 32'h22, 1'b0, 1'b0, 2);
    waitRsp("ptrKeep1", 32'h11, 1'b0, 1'b0, 1);
    check("ptrKeepFirst", 64'(grantLog[0]), 64'(2));

    pushReq(0, 32'h3, 32'h5, 1'b1);
    waitRsp("sub3m5", 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    pushReq(0, 32'h8000_0000, 32'h1, 1'b1);
    waitRsp("subOvf", 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
    pushReq(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    waitRsp("addWrap", 32'h0, 1'b1, 1'b0, 0);

    resetDut();
    #4 grantLog.delete(); grantCyc.delete();
    for (int k = 0; k < N; k++) pushReq(k, 32'(k * 3), 32'(k), 1'b0);
    pushReq(0, 32'h100, 32'h1, 1'b0);
    pushReq(1, 32'h200, 32'h2, 1'b0);
    repeat (10) @(negedge clk);
    check("rrCount", 64'(grantLog.size()), 64'(6));
    if (grantLog.size() == 6) begin
      for (int i = 0; i < 6; i++) check("rrOrder", 64'(grantLog[i]), 64'(i % 4));
      check("rrNoBubble", 64'(grantCyc[5] - grantCyc[0]), 64'(5));
    end

    @(negedge clk); rspReady = '0;
    #4 pushReq(2, 32'd100, 32'd23, 1'b0);
    waitRsp("bpFirst", 32'd123, 1'b0, 1'b0, 2);
    pushReq(0, 32'd7, 32'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rspReady = 4'b0010;
      #4;
      check("bpNoGrant", 64'(reqReady), 64'(0));
      check("bpHeld", 64'({rspSum, rspOwner}), 64'({32'd123, 2'd2}));
    end
    @(negedge clk); rspReady = 4'b0100;
    #4 check("bpRefill", 64'(reqReady), 64'(4'b0001));
    @(negedge clk); rspReady = '1;
    #4 check("bpNewOwner", 64'({rspSum, rspCOut, rspOwner}), 64'({32'd0, 1'b1, 2'd0}));

    @(negedge clk); rspReady = '0;
    #4 pushReq(3, 32'd1, 32'd2, 1'b0);
    waitRsp("preReset", 32'd3, 1'b0, 1'b0, 3);
    resetDut();
    #4 checkZero("midReset");
    grantLog.delete();
    pushReq(1, 32'd9, 32'd1, 1'b0);
    pushReq(0, 32'd8, 32'd1, 1'b0);
    @(negedge clk); rspReady = '1;
    repeat (4) @(negedge clk);
    check("postResetFirst", 64'(grantLog.size() > 0 ? grantLog[0] : -1), 64'(0));

    randMode = 1'b1;
    repeat (1500) @(negedge clk);
    resetDut();
    repeat (1500) @(negedge clk);
    randMode = 1'b0;
    @(negedge clk); rspReady = '1;
    n = 0;
    do begin
      @(negedge clk);
      busy = expQ.size() + int'(reqValid != '0);
      for (int k = 0; k < N; k++) busy += reqQ[k].size();
      n++;
    end while (busy != 0 && n < 200);
    if (busy != 0) begin
      checks++; errors++;
      $display("FAIL drain: traffic still pending after 200 cycles, got %0d expected 0", busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
Round-robin arbiter and sequencer that time-shares one 32-bit carry-select adder (the existing Adder module, instantiated once inside this block) between N_REQ requesters, e.g. ALU, branch-target and load/store address generation.
It accepts one add/subtract request per cycle with valid/ready handshakes and computes the sum in the accept cycle. It registers the result plus owner ID and returns it through a per-requester valid/ready response with back-pressure.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, owner-ID width; must equal clog2(N_REQ), minimum 1

Ports:
i_clk_1  in  1  clock, rising edge
i_rst_1  in  1  synchronous active-high reset
i_reqValid_N  in  N_REQ  request valid, bit k = requester k
o_reqReady_N  out  N_REQ  one-hot grant/accept; at most one bit set
i_reqOp1_N32  in  N_REQ*32  operand 1, requester k at [32k+31:32k]
i_reqOp2_N32  in  N_REQ*32  operand 2, same packing
i_reqSub_N  in  N_REQ  1 = subtract (op1 - op2), 0 = add
o_rspValid_N  out  N_REQ  one-hot response valid to owner
i_rspReady_N  in  N_REQ  response ready per requester
o_rspSum_32  out  32  registered result
o_rspCOut_1  out  1  carry out (for subtract: 1 = no borrow)
o_rspOvf_1  out  1  signed overflow
o_rspOwner_ID  out  ID_W  index of requester owning the current response

Behaviour:
- Reset: i_rst_1 sampled at a rising edge. State -> EMPTY. Priority pointer -> 0. All outputs 0, including o_rspValid_N, o_rspSum_32, o_rspCOut_1, o_rspOvf_1 and o_rspOwner_ID. Any held result is discarded. Reset mid-transaction drops it without any response.
- Result-slot FSM, two states:
  - EMPTY: no response pending.
  - FULL: result held; o_rspValid_N[owner] = 1.
- canAccept = (state == EMPTY) | (state == FULL & i_rspReady_N[owner]).
- Arbitration (combinational):
  - Search i_reqValid_N starting at index ptr and wrapping modulo N_REQ.
  - The first set bit g wins.
  - o_reqReady_N = canAccept ? onehot(g) : 0. It is 0 when no request is valid.
- Accept cycle, when i_reqValid_N[g] & o_reqReady_N[g]:
  - Adder inputs: op1 = Op1[g]; op2 = Sub[g] ? ~Op2[g] : Op2[g]; cin = Sub[g].
  - Next edge: register sum, cOut and ovf, set owner = g, state FULL.
  - Ovf = (op1[31] == op2eff[31]) & (sum[31] != op1[31]).
  - Pointer update: ptr <= (g + 1) mod N_REQ. The pointer updates only on accept.
- Latency: request accepted at edge t, response valid in the cycle following edge t.
- Throughput: 1 result/cycle when the owner holds rspReady.
- Transitions:
  - EMPTY & no accept -> EMPTY.
  - EMPTY & accept -> FULL.
  - FULL & owner ready & accept -> FULL: new result, new owner, same edge, no bubble.
  - FULL & owner ready & no accept -> EMPTY; rspValid drops next cycle.
  - FULL & !owner ready -> FULL. Sum, owner and flags held stable; o_reqReady_N = 0.
- i_rspReady_N bits of non-owners are ignored.
- Requester protocol: once valid is raised, the requester keeps valid, operands and Sub stable until ready. Dropping valid early is illegal and not checked.
- A requester may issue a new request while its previous response is still pending in the slot. If it wins, it is granted only under the drain-and-refill rule above.
- Arithmetic wraps modulo 2^32; no saturation.
- Starvation bound: a continuously valid requester is granted within N_REQ accepts.
- Latch-free: every combinational signal assigned in all paths.

Test Plan:
- Single add: req1 op1=0x0000_0005, op2=0x0000_0003, sub=0, rspReady=1 -> reqReady=0b0010 same cycle. Next cycle: rspValid=0b0010, sum=0x0000_0008, cOut=0, ovf=0, owner=1.
- Subtract and borrow:
  - req0 op1=3, op2=5, sub=1 -> sum=0xFFFF_FFFE, cOut=0.
  - op1=0x8000_0000, op2=1, sub=1 -> sum=0x7FFF_FFFF, cOut=1, ovf=1.
  - op1=0xFFFF_FFFF, op2=1, add -> sum=0, cOut=1, ovf=0.
- Round-robin: all 4 valid continuously, rspReady=0xF -> grant order 0,1,2,3,0,1, one per cycle, no bubble cycles.
- Back-pressure:
  - Owner 2 rspReady=0 for 3 cycles with req0 valid -> reqReady=0 throughout; sum and owner held.
  - Raise rspReady[2] -> req0 granted that same cycle.
  - Next cycle: owner=0.
  - Asserting rspReady[1] while owner=2 has no effect.
- Reset mid-operation: state FULL with owner=3, assert i_rst_1 one cycle -> next cycle all outputs 0. Then req1 and req0 valid -> req0 granted first (ptr=0).
- Idle drain: single response consumed with no new requests -> rspValid=0 next cycle; state EMPTY; ptr unchanged.
